// File: rtl/video_pattern_gen.sv
// Parametrised video source: frames of programmable size and blanking, four
// pattern modes, valid/ready output with registered pixel and sideband flags.
module video_pattern_gen #(
  parameter int G_DATA_WIDTH   = 8,
  parameter int G_NUM_CHANNELS = 3
) (
  input  logic                                   SYS_CLK_I,
  input  logic                                   RESETN_I,
  input  logic                                   ENABLE_I,
  input  logic [12:0]                            HORZ_RES_I,
  input  logic [12:0]                            VERT_RES_I,
  input  logic [12:0]                            H_BLANK_I,
  input  logic [15:0]                            V_BLANK_I,
  input  logic [15:0]                            NUM_FRAMES_I,
  input  logic [1:0]                             MODE_I,
  input  logic [G_DATA_WIDTH*G_NUM_CHANNELS-1:0] SOLID_COLOR_I,
  input  logic                                   READY_I,
  output logic                                   DATA_VALID_O,
  output logic [G_DATA_WIDTH*G_NUM_CHANNELS-1:0] DATA_O,
  output logic                                   FRAME_START_O,
  output logic                                   LINE_END_O,
  output logic                                   FRAME_END_O,
  output logic                                   BUSY_O,
  output logic                                   DONE_O,
  output logic [15:0]                            FRAME_COUNT_O
);
  localparam int PW = G_DATA_WIDTH * G_NUM_CHANNELS;

  typedef enum logic [2:0] {S_IDLE, S_ACTIVE, S_HBLANK, S_VBLANK, S_DONE} state_t;

  state_t        state, state_n;
  logic [12:0]   x, x_n, y, y_n, bcnt, bcnt_n, bar_w;
  logic [12:0]   h_q, h_n, v_q, v_n, hb_q, hb_n;
  logic [2:0]    bar, bar_n, rgb;
  logic [15:0]   blank, blank_n, fc_n, vb_q, vb_n, nf_q, nf_n;
  logic [1:0]    mode_q, mode_n;
  logic [PW-1:0] solid_q, solid_n, data_n;
  logic [G_DATA_WIDTH-1:0] xv, yv;
  logic          beat, start_ok, relatch, vexit;
  logic          valid_n, fs_n, le_n, fe_n;

  assign beat     = DATA_VALID_O & READY_I;
  assign start_ok = ENABLE_I && (HORZ_RES_I != '0) && (VERT_RES_I != '0);
  assign bar_w    = (h_q[12:3] == '0) ? 13'd1 : {3'b000, h_q[12:3]};

  // Colour-bar order white..black as {B,G,R}; bit n drives channel n mod 3.
  function automatic logic [2:0] bar_rgb(input logic [2:0] b);
    case (b)
      3'd0:    bar_rgb = 3'd7;
      3'd1:    bar_rgb = 3'd3;
      3'd2:    bar_rgb = 3'd6;
      3'd3:    bar_rgb = 3'd2;
      3'd4:    bar_rgb = 3'd5;
      3'd5:    bar_rgb = 3'd1;
      3'd6:    bar_rgb = 3'd4;
      default: bar_rgb = 3'd0;
    endcase
  endfunction

  always_ff @(posedge SYS_CLK_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      state         <= S_IDLE;
      x             <= '0;
      y             <= '0;
      bar           <= '0;
      bcnt          <= '0;
      blank         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      hb_q          <= '0;
      vb_q          <= '0;
      nf_q          <= '0;
      mode_q        <= '0;
      solid_q       <= '0;
      DATA_VALID_O  <= 1'b0;
      DATA_O        <= '0;
      FRAME_START_O <= 1'b0;
      LINE_END_O    <= 1'b0;
      FRAME_END_O   <= 1'b0;
      BUSY_O        <= 1'b0;
      DONE_O        <= 1'b0;
      FRAME_COUNT_O <= '0;
    end else begin
      state         <= state_n;
      x             <= x_n;
      y             <= y_n;
      bar           <= bar_n;
      bcnt          <= bcnt_n;
      blank         <= blank_n;
      h_q           <= h_n;
      v_q           <= v_n;
      hb_q          <= hb_n;
      vb_q          <= vb_n;
      nf_q          <= nf_n;
      mode_q        <= mode_n;
      solid_q       <= solid_n;
      DATA_VALID_O  <= valid_n;
      DATA_O        <= data_n;
      FRAME_START_O <= fs_n;
      LINE_END_O    <= le_n;
      FRAME_END_O   <= fe_n;
      BUSY_O        <= (state_n != S_IDLE);
      DONE_O        <= (state_n == S_DONE);
      FRAME_COUNT_O <= fc_n;
    end
  end

  always_comb begin
    state_n = state;
    x_n     = x;
    y_n     = y;
    bar_n   = bar;
    bcnt_n  = bcnt;
    blank_n = blank;
    fc_n    = FRAME_COUNT_O;
    h_n     = h_q;
    v_n     = v_q;
    hb_n    = hb_q;
    vb_n    = vb_q;
    nf_n    = nf_q;
    mode_n  = mode_q;
    solid_n = solid_q;
    relatch = 1'b0;
    vexit   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_ok) begin
          relatch = 1'b1;
          x_n     = '0;
          y_n     = '0;
          fc_n    = '0;
          state_n = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (beat) begin
          if (x == h_q - 13'd1) begin
            x_n = '0;
            if (y != v_q - 13'd1) begin
              y_n = y + 13'd1;
              if (hb_q != '0) begin
                state_n = S_HBLANK;
                blank_n = {3'b000, hb_q} - 16'd1;
              end
            end else begin
              fc_n = FRAME_COUNT_O + 16'd1;
              if (nf_q != '0 && fc_n == nf_q) begin
                state_n = S_DONE;
              end else if (vb_q != '0) begin
                state_n = S_VBLANK;
                blank_n = vb_q - 16'd1;
              end else begin
                vexit = 1'b1;
              end
            end
          end else begin
            x_n = x + 13'd1;
          end
        end
      end
      S_HBLANK: begin
        if (blank == '0) state_n = S_ACTIVE;
        else             blank_n = blank - 16'd1;
      end
      S_VBLANK: begin
        if (blank == '0) vexit = 1'b1;
        else             blank_n = blank - 16'd1;
      end
      S_DONE: begin
        if (!ENABLE_I) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    // Frame boundary: continue with fresh config, or fall back to IDLE.
    if (vexit) begin
      if (start_ok) begin
        relatch = 1'b1;
        x_n     = '0;
        y_n     = '0;
        state_n = S_ACTIVE;
      end else begin
        state_n = S_IDLE;
      end
    end
    if (relatch) begin
      h_n     = HORZ_RES_I;
      v_n     = VERT_RES_I;
      hb_n    = H_BLANK_I;
      vb_n    = V_BLANK_I;
      nf_n    = NUM_FRAMES_I;
      mode_n  = MODE_I;
      solid_n = SOLID_COLOR_I;
    end
    // Bar index follows x without a divider: count pixels within the current bar.
    if (x_n == '0) begin
      bar_n  = '0;
      bcnt_n = '0;
    end else if (beat) begin
      if (bcnt == bar_w - 13'd1) begin
        bcnt_n = '0;
        if (bar != 3'd7) bar_n = bar + 3'd1;
      end else begin
        bcnt_n = bcnt + 13'd1;
      end
    end
  end

  always_comb begin
    valid_n = (state_n == S_ACTIVE);
    le_n    = valid_n && (x_n == h_n - 13'd1);
    fe_n    = le_n && (y_n == v_n - 13'd1);
    fs_n    = valid_n && (x_n == '0) && (y_n == '0);
    rgb     = bar_rgb(bar_n);
    xv      = '0;
    yv      = '0;
    for (int unsigned i = 0; i < G_DATA_WIDTH; i++) begin
      if (i < 13) begin
        xv[i] = x_n[i];
        yv[i] = y_n[i];
      end
    end
    data_n = '0;
    if (valid_n) begin
      for (int unsigned c = 0; c < G_NUM_CHANNELS; c++) begin
        case (mode_n)
          2'd0:    data_n[c*G_DATA_WIDTH +: G_DATA_WIDTH] = solid_n[c*G_DATA_WIDTH +: G_DATA_WIDTH];
          2'd1:    data_n[c*G_DATA_WIDTH +: G_DATA_WIDTH] = xv;
          2'd2:    data_n[c*G_DATA_WIDTH +: G_DATA_WIDTH] = yv;
          default: data_n[c*G_DATA_WIDTH +: G_DATA_WIDTH] = {G_DATA_WIDTH{rgb[c % 3]}};
        endcase
      end
    end
  end
endmodule
